// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the fetch front end: default address width and
//   reset vector, the 32-bit instruction length code, and the PC generator
//   state encoding.
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

  // Low two bits of a parcel that mark a full-width (non-compressed) instruction.
  localparam logic [1:0]  ILEN32_CODE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,  // just out of reset, pc not yet live
    RUN        = 2'd1,  // normal sequential / redirect operation
    HOLD_REDIR = 2'd2   // a redirect was captured while stalled
  } pc_state_t;

endpackage : core_pkg

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
//   Bundles the fetch-side inputs and PC outputs of pc_gen.
//   master : the fetch/redirect side (drives parcel info, stall, redirects)
//   slave  : pc_gen itself
//   Signals:
//     fetch_valid, ins_2bit_l0, stall, redir_en, redir_addr  -> into pc_gen
//     pc, pc_valid, next_pc, next_pc_add2, redir_pending,
//     redir_misalign                                          <- from pc_gen
// -----------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 2
);

  logic                      fetch_valid;
  logic [1:0]                ins_2bit_l0;
  logic                      stall;
  logic [NUM_REDIR-1:0]      redir_en;
  logic [NUM_REDIR*XLEN-1:0] redir_addr;

  logic [XLEN-1:0]           pc;
  logic                      pc_valid;
  logic [XLEN-1:0]           next_pc;
  logic [XLEN-1:0]           next_pc_add2;
  logic                      redir_pending;
  logic                      redir_misalign;

  modport master (
    output fetch_valid, ins_2bit_l0, stall, redir_en, redir_addr,
    input  pc, pc_valid, next_pc, next_pc_add2, redir_pending, redir_misalign
  );

  modport slave (
    input  fetch_valid, ins_2bit_l0, stall, redir_en, redir_addr,
    output pc, pc_valid, next_pc, next_pc_add2, redir_pending, redir_misalign
  );

endinterface : pc_gen_if

// File: rtl/pc_gen_redir_arb.sv
// -----------------------------------------------------------------------------
// redir_arb
//   Priority select over NUM_REDIR redirect sources; the highest index with
//   its enable set wins. The winning target is aligned to the instruction
//   granule (2 bytes with compressed support, 4 bytes without) and
//   misalign flags that a set low bit was cleared.
//   Ports:
//     redir_en     in  NUM_REDIR       per-source request
//     redir_addr   in  NUM_REDIR*XLEN  packed targets, source i at [i*XLEN +: XLEN]
//     hit          out 1               any source requesting
//     aligned_addr out XLEN            aligned winning target (0 when no hit)
//     misalign     out 1               winner had a bit cleared by alignment
// -----------------------------------------------------------------------------
module redir_arb #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 2,
  parameter int C_EXT     = 1
) (
  input  logic [NUM_REDIR-1:0]      redir_en,
  input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
  output logic                      hit,
  output logic [XLEN-1:0]           aligned_addr,
  output logic                      misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);

  logic [XLEN-1:0] raw_addr;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise an unassigned path infers a latch.
    hit      = 1'b0;
    raw_addr = '0;
    // Ascending scan: a later (higher) index overwrites, so it has priority.
    for (int i = 0; i < NUM_REDIR; i++) begin
      if (redir_en[i]) begin
        hit      = 1'b1;
        raw_addr = redir_addr[i*XLEN +: XLEN];
      end
    end
    aligned_addr = raw_addr & ALIGN_MASK;
    misalign     = hit && (|(raw_addr & ~ALIGN_MASK));
  end

endmodule : redir_arb

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Fetch program-counter generator. Advances pc by 4 (32-bit parcel) or
//   2 (compressed parcel), applies the highest-priority redirect, and keeps a
//   redirect that arrives under stall until the stall releases.
//   Ports:
//     clk  in  clock
//     rst  in  synchronous active-high reset
//     bus  pc_gen_if.slave  fetch inputs and PC outputs
// -----------------------------------------------------------------------------
module pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              NUM_REDIR = 2,
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int              C_EXT     = 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  pc_state_t       state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_addr_q;
  logic            pend_mis_q;
  logic            misalign_q;

  logic            arb_hit;
  logic [XLEN-1:0] arb_addr;
  logic            arb_mis;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] nxt;

  redir_arb #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR),
    .C_EXT     (C_EXT)
  ) u_arb (
    .redir_en     (bus.redir_en),
    .redir_addr   (bus.redir_addr),
    .hit          (arb_hit),
    .aligned_addr (arb_addr),
    .misalign     (arb_mis)
  );

  always_comb begin
    step = '0;
    if (bus.fetch_valid) begin
      step = (bus.ins_2bit_l0 == ILEN32_CODE || C_EXT == 0) ? XLEN'(4) : XLEN'(2);
    end

    // IDLE holds the reset vector; otherwise fresh redirect > pending > increment.
    if (state_q == IDLE)   nxt = pc_q;
    else if (arb_hit)      nxt = arb_addr;
    else if (pend_q)       nxt = pend_addr_q;
    else                   nxt = pc_q + step;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_mis_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      state_q    <= RUN;
      pc_valid_q <= 1'b1;
      misalign_q <= 1'b0;
    end else if (!bus.stall) begin
      // Any pending redirect is consumed here; a fresh one already took
      // precedence in nxt, so the pending target is simply dropped.
      pc_q       <= nxt;
      pend_q     <= 1'b0;
      state_q    <= RUN;
      misalign_q <= arb_hit ? arb_mis : (pend_q && pend_mis_q);
    end else begin
      misalign_q <= 1'b0;
      // Youngest redirect under stall overwrites any earlier capture.
      if (arb_hit) begin
        pend_q      <= 1'b1;
        pend_addr_q <= arb_addr;
        pend_mis_q  <= arb_mis;
        state_q     <= HOLD_REDIR;
      end
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_valid       = pc_valid_q;
  assign bus.next_pc        = nxt;
  assign bus.next_pc_add2   = nxt + XLEN'(2);
  assign bus.redir_pending  = pend_q;
  assign bus.redir_misalign = misalign_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
//   Drives two pc_gen instances (compressed enabled / disabled). Expected
//   post-edge state is queued when stimulus is applied and compared after the
//   following rising edge; combinational next_pc is checked in-cycle.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) if0 ();
  pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) if1 ();

  pc_gen #(.XLEN(32), .NUM_REDIR(2), .RESET_PC(32'h8000_0000), .C_EXT(1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  pc_gen #(.XLEN(32), .NUM_REDIR(2), .RESET_PC(32'h8000_0000), .C_EXT(0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  typedef struct {
    int          dut;
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instance; the other gets idle inputs. Returns 1 ns after driving.
  task automatic apply(input int dut, input logic fv, input logic [1:0] ins, input logic st,
                       input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1);
    if0.fetch_valid = 1'b0; if0.ins_2bit_l0 = 2'b00; if0.stall = 1'b0;
    if0.redir_en = 2'b00;   if0.redir_addr = '0;
    if1.fetch_valid = 1'b0; if1.ins_2bit_l0 = 2'b00; if1.stall = 1'b0;
    if1.redir_en = 2'b00;   if1.redir_addr = '0;
    if (dut == 0) begin
      if0.fetch_valid = fv; if0.ins_2bit_l0 = ins; if0.stall = st;
      if0.redir_en = en;    if0.redir_addr = {a1, a0};
    end else begin
      if1.fetch_valid = fv; if1.ins_2bit_l0 = ins; if1.stall = st;
      if1.redir_en = en;    if1.redir_addr = {a1, a0};
    end
    #1;
  endtask

  task automatic chk_next(input string tag, input int dut, input logic [31:0] exp);
    if (dut == 0) begin
      check({tag, ".next_pc"}, if0.next_pc, exp);
      check({tag, ".add2"}, if0.next_pc_add2, exp + 32'd2);
    end else begin
      check({tag, ".next_pc"}, if1.next_pc, exp);
      check({tag, ".add2"}, if1.next_pc_add2, exp + 32'd2);
    end
  endtask

  task automatic expect_q(input int dut, input string tag, input logic [31:0] pc,
                          input logic v, input logic p, input logic m);
    exp_t e;
    e.dut = dut; e.tag = tag; e.pc = pc; e.valid = v; e.pend = p; e.mis = m;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard consumer: everything queued before an edge is compared after it.
  always @(posedge clk) begin
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        check({e.tag, ".pc"},       if0.pc,             e.pc);
        check({e.tag, ".valid"},    32'(if0.pc_valid),  32'(e.valid));
        check({e.tag, ".pending"},  32'(if0.redir_pending),  32'(e.pend));
        check({e.tag, ".misalign"}, 32'(if0.redir_misalign), 32'(e.mis));
      end else begin
        check({e.tag, ".pc"},       if1.pc,             e.pc);
        check({e.tag, ".valid"},    32'(if1.pc_valid),  32'(e.valid));
        check({e.tag, ".pending"},  32'(if1.redir_pending),  32'(e.pend));
        check({e.tag, ".misalign"}, 32'(if1.redir_misalign), 32'(e.mis));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  initial begin
    apply(0, 1'b0, 2'b00, 1'b0, 2'b00, '0, '0);
    tick();

    // ---- 1. reset and compressed increment ----
    rst = 1'b1;
    apply(0, 1'b0, 2'b00, 1'b0, 2'b00, '0, '0);
    expect_q(0, "rst_a", RST_PC, 0, 0, 0); expect_q(1, "rst_a1", RST_PC, 0, 0, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b0, 2'b00, '0, '0);
    chk_next("rst_b", 0, RST_PC);
    expect_q(0, "rst_b", RST_PC, 0, 0, 0); expect_q(1, "rst_b1", RST_PC, 0, 0, 0);
    tick();
    rst = 1'b0;
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("idle", 0, RST_PC);
    expect_q(0, "idle", RST_PC, 1, 0, 0); expect_q(1, "idle1", RST_PC, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("inc4", 0, 32'h8000_0004);
    expect_q(0, "inc4", 32'h8000_0004, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b01, 1'b0, 2'b00, '0, '0);
    chk_next("inc2", 0, 32'h8000_0006);
    expect_q(0, "inc2", 32'h8000_0006, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("inc4b", 0, 32'h8000_000A);
    expect_q(0, "inc4b", 32'h8000_000A, 1, 0, 0);
    tick();

    // ---- 2. simultaneous redirects ----
    apply(0, 1'b1, 2'b11, 1'b0, 2'b11, 32'h100, 32'h200);
    chk_next("both", 0, 32'h200);
    expect_q(0, "both", 32'h200, 1, 0, 0);
    tick();

    // ---- 3. redirect under stall ----
    apply(0, 1'b1, 2'b11, 1'b1, 2'b00, '0, '0);
    chk_next("stA", 0, 32'h204);
    expect_q(0, "stA", 32'h200, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b1, 2'b01, 32'h40, '0);
    chk_next("stB", 0, 32'h40);
    expect_q(0, "stB", 32'h200, 1, 1, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b1, 2'b00, '0, '0);
    chk_next("stC", 0, 32'h40);
    expect_q(0, "stC", 32'h200, 1, 1, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b0, 2'b00, '0, '0);
    chk_next("stD", 0, 32'h40);
    expect_q(0, "stD", 32'h40, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("stE", 0, 32'h44);
    expect_q(0, "stE", 32'h44, 1, 0, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b1, 2'b00, '0, '0);
    expect_q(0, "st2A", 32'h44, 1, 0, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b1, 2'b01, 32'h40, '0);
    expect_q(0, "st2B", 32'h44, 1, 1, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b1, 2'b00, '0, '0);
    expect_q(0, "st2C", 32'h44, 1, 1, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b0, 2'b10, '0, 32'h80);
    chk_next("st2D", 0, 32'h80);
    expect_q(0, "st2D", 32'h80, 1, 0, 0);
    tick();

    // ---- 4. misalignment (C_EXT=1 then C_EXT=0) ----
    apply(0, 1'b0, 2'b00, 1'b0, 2'b01, 32'h103, '0);
    chk_next("mis1", 0, 32'h102);
    expect_q(0, "mis1", 32'h102, 1, 0, 1);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("mis1b", 0, 32'h106);
    expect_q(0, "mis1b", 32'h106, 1, 0, 0);
    tick();
    apply(1, 1'b0, 2'b00, 1'b0, 2'b01, 32'h103, '0);
    chk_next("nc_mis", 1, 32'h100);
    expect_q(1, "nc_mis", 32'h100, 1, 0, 1);
    tick();
    apply(1, 1'b1, 2'b01, 1'b0, 2'b00, '0, '0);
    chk_next("nc_inc", 1, 32'h104);
    expect_q(1, "nc_inc", 32'h104, 1, 0, 0);
    tick();
    apply(1, 1'b0, 2'b00, 1'b0, 2'b01, 32'h102, '0);
    chk_next("nc_mis2", 1, 32'h100);
    expect_q(1, "nc_mis2", 32'h100, 1, 0, 1);
    tick();

    // ---- 5. wrap-around and hold ----
    apply(0, 1'b0, 2'b00, 1'b0, 2'b01, 32'hFFFF_FFFC, '0);
    chk_next("wr_set", 0, 32'hFFFF_FFFC);
    expect_q(0, "wr_set", 32'hFFFF_FFFC, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("wr4", 0, 32'h0000_0000);
    expect_q(0, "wr4", 32'h0000_0000, 1, 0, 0);
    tick();
    apply(0, 1'b0, 2'b00, 1'b0, 2'b01, 32'hFFFF_FFFC, '0);
    expect_q(0, "wr_set2", 32'hFFFF_FFFC, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b01, 1'b0, 2'b00, '0, '0);
    chk_next("wr2", 0, 32'hFFFF_FFFE);
    expect_q(0, "wr2", 32'hFFFF_FFFE, 1, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 1'b0, 2'b11, 1'b0, 2'b00, '0, '0);
      chk_next($sformatf("hold%0d", i), 0, 32'hFFFF_FFFE);
      expect_q(0, $sformatf("hold%0d", i), 32'hFFFF_FFFE, 1, 0, 0);
      tick();
    end

    // ---- 6. reset with a pending redirect and a fresh redirect ----
    apply(0, 1'b0, 2'b00, 1'b1, 2'b01, 32'h300, '0);
    expect_q(0, "pend", 32'hFFFF_FFFE, 1, 1, 0);
    tick();
    rst = 1'b1;
    apply(0, 1'b0, 2'b00, 1'b0, 2'b10, '0, 32'h500);
    chk_next("rst_redir", 0, 32'h500);
    expect_q(0, "rst_pend", RST_PC, 0, 0, 0);
    tick();
    rst = 1'b0;
    apply(0, 1'b0, 2'b00, 1'b0, 2'b00, '0, '0);
    chk_next("idle2", 0, RST_PC);
    expect_q(0, "idle2", RST_PC, 1, 0, 0);
    tick();
    apply(0, 1'b1, 2'b11, 1'b0, 2'b00, '0, '0);
    chk_next("restart", 0, 32'h8000_0004);
    expect_q(0, "restart", 32'h8000_0004, 1, 0, 0);
    tick();

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end. It holds the architectural fetch PC and advances it by 4 or 2 depending on whether the current parcel is a compressed instruction. It arbitrates any number of prioritised redirect sources (branch resolve, exception/trap, flush, …) and honours a fetch stall. A redirect that arrives while fetch is stalled is captured and applied when the stall releases, so no redirect is ever lost.

## Interface

Parameters:
- `XLEN`, 32: PC / address width.
- `NUM_REDIR`, 2: number of redirect sources; a higher index has higher priority.
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.
- `C_EXT`, 1: compressed support. When 0, every instruction advances by 4 and redirect bit[1] is also forced to 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high, single clock domain.
- `fetch_valid` in 1: the parcel at `pc` is available. `ins_2bit_l0` is meaningful only when this is high.
- `ins_2bit_l0` in 2: low 2 bits of the instruction at `pc`. 2'b11 means 32-bit; anything else means compressed.
- `stall` in 1: the downstream stage cannot accept; `pc` must hold.
- `redir_en` in NUM_REDIR: per-source redirect request.
- `redir_addr` in NUM_REDIR*XLEN: packed targets; source i occupies `[i*XLEN +: XLEN]`.
- `pc` out XLEN: registered current fetch PC.
- `pc_valid` out 1: `pc` is a live fetch address.
- `next_pc` out XLEN: combinational value `pc` takes at the next edge if not stalled.
- `next_pc_add2` out XLEN: `next_pc + 2`, modulo 2^XLEN.
- `redir_pending` out 1: a captured redirect is waiting for the stall to release.
- `redir_misalign` out 1: one-cycle pulse when the applied target had a low bit cleared by alignment.

## Operation

- **Sequential increment.** When `fetch_valid` is high, the step is 4 if `ins_2bit_l0 == 2'b11` or `C_EXT == 0`, otherwise 2. When `fetch_valid` is low, the step is 0 and the PC holds.
- **Redirect arbitration.** The winner is the highest index i with `redir_en[i]` set.
- **Target alignment.** Bit[0] is forced to 0. Bit[1] is also forced to 0 when `C_EXT == 0`. `redir_misalign` pulses if any forced bit was 1.
- **`next_pc` priority:**
  1. fresh redirect winner this cycle;
  2. pending redirect register;
  3. `pc + step`.
- **`pc` update.** On each edge with `stall == 0`, `pc <= next_pc`.
- **Redirect under stall.** On an edge with `stall == 1` and a fresh redirect, the aligned winner is written into the pending register and `redir_pending <= 1`. A later fresh redirect during the same stall overwrites it, because the youngest request is the most authoritative.
- **Pending redirect release.** The pending register is consumed (`redir_pending <= 0`) on the first non-stalled edge. If a fresh redirect is present on that edge, the fresh one wins and the pending one is discarded.
- **PC during redirect under stall.** `pc` never changes during stall, even with a redirect.
- **Wrap-around.** All adds are modulo 2^XLEN. Example: `pc = FFFF_FFFC` with a 32-bit instruction gives `0000_0000`.
- **State machine.** States are IDLE (after reset, `pc_valid = 0`), RUN, and HOLD_REDIR (pending set).
  - IDLE → RUN on the first edge after `rst` deasserts.
  - RUN → HOLD_REDIR on a redirect while stalled.
  - HOLD_REDIR → RUN on the first non-stalled edge.

## Timing

- **Reset values.**
  - `pc = RESET_PC`, `pc_valid = 0`, `redir_pending = 0`, `redir_misalign = 0`, state IDLE.
  - `next_pc = RESET_PC` while in IDLE; the increment is suppressed in IDLE.
- **`pc_valid`.** Goes to 1 on the first edge after `rst` drops, and stays 1 until the next reset.
- **Redirect latency.** A redirect is visible combinationally on `next_pc` in the same cycle, and on `pc` after one edge if unstalled.
- **Increment latency.** Also one edge.
- **`redir_misalign`.** Registered; asserted in the cycle after the edge that applied the misaligned target.
- **Reset mid-operation.** `rst` overrides everything, including a pending redirect and any fresh redirect on the same edge.

## Structure

- **Shared package (`core_pkg`):**
  - `XLEN` default;
  - `RESET_PC` default;
  - `ILEN32_CODE = 2'b11`;
  - a `pc_state_t` enum with `IDLE`, `RUN`, `HOLD_REDIR`.
- **Sub-module `redir_arb`:** a natural standalone block. It is a parametrised priority select over `NUM_REDIR` sources and returns `{hit, aligned_addr, misalign}`, and is reusable for other flush muxes.
- **Size.** The remainder is a single always_ff/always_comb pair; expected size is ~150–250 lines.

## Test plan

1. **Reset and compressed increment.** Hold `rst` for 2 cycles, release, then `fetch_valid = 1` with `ins_2bit_l0` = 11, 01, 11. Required: `pc` = 8000_0000, then `pc_valid = 1`, then 8000_0004 → 8000_0006 → 8000_000A; `next_pc_add2 = next_pc + 2` throughout.
2. **Simultaneous redirects.** `redir_en = 2'b11` with addr0 = 100, addr1 = 200. Required: `next_pc = 200` the same cycle, `pc = 200` after the edge.
3. **Redirect under stall.** Assert `stall` for 3 cycles and pulse `redir_en[0] = 1` (addr 0x40) in the 2nd cycle. Required: `pc` frozen, `redir_pending = 1`, and after the stall drops `pc = 0x40` and `redir_pending = 0`. Repeat with a fresh `redir_en[1]` (0x80) on the release cycle: `pc = 0x80`.
4. **Misalignment.** Redirect to 0x103 with `C_EXT = 1`: `pc = 0x102`, `redir_misalign` pulses. With `C_EXT = 0`: `pc = 0x100`, pulse, and `ins_2bit_l0 = 01` still advances by 4.
5. **Wrap-around and hold.** Set `pc = FFFF_FFFC` with a 32-bit instruction: next `pc = 0000_0000`. Set `fetch_valid = 0` for 2 cycles: `pc` unchanged.
6. **Reset with pending.** Set `redir_pending = 1`, then assert `rst` together with a fresh redirect. Required: `pc = RESET_PC`, `redir_pending = 0`, `pc_valid = 0`.
